// File: rtl/result_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_writer_pkg
// Purpose  : Shared types for the result write-back engine.
// Revision : 1.0 - initial release
// ============================================================================
package result_writer_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_RUN  = 2'd1,
        WB_DONE = 2'd2
    } wb_state_t;

    typedef logic [1:0] elem_idx_t;

    localparam elem_idx_t IDX_C11 = 2'd0;
    localparam elem_idx_t IDX_C12 = 2'd1;
    localparam elem_idx_t IDX_C21 = 2'd2;
    localparam elem_idx_t IDX_C22 = 2'd3;

    typedef struct packed {
        logic signed [31:0] data;
        elem_idx_t          idx;
    } wb_entry_t;

    // Strobe vector is {c22, c21, c12, c11}; the lowest set bit wins.
    function automatic elem_idx_t pick_idx(input logic [3:0] strb);
        if (strb[0]) return IDX_C11;
        if (strb[1]) return IDX_C12;
        if (strb[2]) return IDX_C21;
        return IDX_C22;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_writer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous FIFO of write-back entries with full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import result_writer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  wb_entry_t                  din,
    input  logic                       pop,
    output wb_entry_t                  dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_writer.sv
`default_nettype none
// ============================================================================
// Module   : result_writer
// Purpose  : Captures 2x2 tile elements and writes them row-major to memory.
//            Optional stall counter enabled by RESULT_WRITER_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module result_writer
    import result_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [15:0]         size,
    input  logic                c11ready,
    input  logic                c12ready,
    input  logic                c21ready,
    input  logic                c22ready,
    input  logic signed [31:0]  C11,
    input  logic signed [31:0]  C12,
    input  logic signed [31:0]  C21,
    input  logic signed [31:0]  C22,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic                mem_gnt,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef RESULT_WRITER_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        ne_q, ne_d;
    logic [15:0]        tc_q, tc_d;
    logic [15:0]        tr_q, tr_d;
    logic [31:0]        wdata_q, wdata_d;
    elem_idx_t          out_idx_q, out_idx_d;
    logic               req_q, req_d;
    logic               err_q, err_d;

    logic [3:0]         strb;
    logic               in_run, cap_any, cap_multi, cap_full, cap_ok;
    logic               grant, out_free, load_fifo, load_cap, fifo_push;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count, occ, occ_next;
    logic [15:0]        size_even, tiles_per_row;
    wb_entry_t          cap_entry, fifo_dout, load_entry;

    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] rb,
        input logic [15:0]       ne,
        input logic [15:0]       tc,
        input elem_idx_t         idx
    );
        logic [ADDR_W-1:0] off;
        off = rb + (idx[1] ? ADDR_W'(ne) : '0) + ADDR_W'({tc, idx[0]});
        return base + (off << 2);
    endfunction

    assign strb = {c22ready, c21ready, c12ready, c11ready};

    always_comb begin
        cap_entry.idx = pick_idx(strb);
        case (cap_entry.idx)
            IDX_C11: cap_entry.data = C11;
            IDX_C12: cap_entry.data = C12;
            IDX_C21: cap_entry.data = C21;
            default: cap_entry.data = C22;
        endcase
    end

    // The output register counts toward capacity, so total buffering is FIFO_DEPTH.
    assign in_run        = (state_q == WB_RUN);
    assign cap_any       = |strb;
    assign cap_multi     = ((strb & (strb - 4'd1)) != 4'd0);
    assign grant         = req_q && mem_gnt;
    assign occ           = fifo_count + CNT_W'(req_q);
    assign cap_full      = fifo_full || (occ == CNT_W'(FIFO_DEPTH));
    assign cap_ok        = in_run && cap_any && (!cap_full || grant);
    assign out_free      = !req_q || grant;
    assign load_fifo     = out_free && !fifo_empty;
    assign load_cap      = out_free && fifo_empty && cap_ok;
    assign fifo_push     = cap_ok && !load_cap;
    assign load_entry    = load_fifo ? fifo_dout : cap_entry;
    assign occ_next      = occ - CNT_W'(grant) + CNT_W'(cap_ok);
    assign size_even     = size & 16'hFFFE;
    assign tiles_per_row = {1'b0, ne_q[15:1]};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (cap_entry),
        .pop     (load_fifo),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        ne_d       = ne_q;
        tc_d       = tc_q;
        tr_d       = tr_q;
        row_base_d = row_base_q;
        err_d      = err_q;
        req_d      = req_q && !grant;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        out_idx_d  = out_idx_q;

        if (grant && (out_idx_q == IDX_C22)) begin
            if (tc_q + 16'd1 == tiles_per_row) begin
                tc_d       = '0;
                tr_d       = tr_q + 16'd1;
                row_base_d = row_base_q + (ADDR_W'(ne_q) << 1);
            end else begin
                tc_d = tc_q + 16'd1;
            end
        end

        // Address uses post-grant tile position so a tile boundary crossed this cycle is honoured.
        if (load_fifo || load_cap) begin
            req_d     = 1'b1;
            wdata_d   = load_entry.data;
            out_idx_d = load_entry.idx;
            addr_d    = elem_addr(base_q, row_base_d, ne_q, tc_d, load_entry.idx);
        end

        case (state_q)
            WB_IDLE: begin
                if (start) begin
                    err_d      = 1'b0;
                    base_d     = base_addr;
                    ne_d       = size_even;
                    tc_d       = '0;
                    tr_d       = '0;
                    row_base_d = '0;
                    state_d    = (size_even >= 16'd2) ? WB_RUN : WB_DONE;
                end
            end
            WB_RUN: begin
                if ((tr_d == tiles_per_row) && (occ_next == '0)) begin
                    state_d = WB_DONE;
                end
            end
            default: state_d = WB_IDLE;
        endcase

        if (cap_any && (!cap_ok || cap_multi)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= WB_IDLE;
            base_q     <= '0;
            ne_q       <= '0;
            tc_q       <= '0;
            tr_q       <= '0;
            row_base_q <= '0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            out_idx_q  <= IDX_C11;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            ne_q       <= ne_d;
            tc_q       <= tc_d;
            tr_q       <= tr_d;
            row_base_q <= row_base_d;
            err_q      <= err_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            out_idx_q  <= out_idx_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = req_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = in_run;
    assign done      = (state_q == WB_DONE);
    assign err       = err_q;

`ifdef RESULT_WRITER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == WB_IDLE) && start) begin
            stall_d = '0;
        end else if (req_q && !mem_gnt && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_writer
// Purpose  : Scoreboard bench for result_writer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_result_writer;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        base_addr = '0;
    logic [15:0]        size = '0;
    logic               c11ready = 1'b0, c12ready = 1'b0, c21ready = 1'b0, c22ready = 1'b0;
    logic signed [31:0] C11 = '0, C12 = '0, C21 = '0, C22 = '0;
    logic               mem_req, mem_we;
    logic [31:0]        mem_addr, mem_wdata;
    logic               mem_gnt = 1'b0;
    logic               busy, done, err;
`ifdef RESULT_WRITER_STALL_CNT_EN
    logic [31:0]        stall_cycles;
`endif

    result_writer #(
        .FIFO_DEPTH (8),
        .ADDR_W     (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .size      (size),
        .c11ready  (c11ready),
        .c12ready  (c12ready),
        .c21ready  (c21ready),
        .c22ready  (c22ready),
        .C11       (C11),
        .C12       (C12),
        .C21       (C21),
        .C22       (C22),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef RESULT_WRITER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    int          cyc = 0;
    int          last_grant_cyc = -1;
    int          m_n, m_tr, m_tc;
    logic [31:0] m_base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && mem_req && mem_gnt) begin
            exp_t e;
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            check("mem_we", 64'(mem_we), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
            n_writes++;
            last_grant_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] data);
        exp_t e;
        e.addr = m_base + 32'(((2 * m_tr + idx / 2) * m_n + 2 * m_tc + idx % 2) * 4);
        e.data = data;
        sb.push_back(e);
        if (idx == 3) begin
            m_tc++;
            if (m_tc == m_n / 2) begin
                m_tc = 0;
                m_tr++;
            end
        end
    endtask

    task automatic send(input int idx, input logic [31:0] data, input bit accept);
        C11 = 32'hBAD0_0011;
        C12 = 32'hBAD0_0012;
        C21 = 32'hBAD0_0021;
        C22 = 32'hBAD0_0022;
        {c22ready, c21ready, c12ready, c11ready} = 4'b0001 << idx;
        case (idx)
            0:       C11 = data;
            1:       C12 = data;
            2:       C21 = data;
            default: C22 = data;
        endcase
        if (accept) push_exp(idx, data);
        tick();
        {c22ready, c21ready, c12ready, c11ready} = 4'b0000;
    endtask

    task automatic start_job(input logic [31:0] b, input logic [15:0] sz);
        base_addr = b;
        size      = sz;
        m_base    = b;
        m_n       = int'(sz & 16'hFFFE);
        m_tr      = 0;
        m_tc      = 0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        int done_cyc;
        int wr_base;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        reset_n = 1'b1;
        tick();

        // Full N=4 job, four tiles, grant always high.
        mem_gnt = 1'b1;
        start_job(32'h1000, 16'd4);
        check("busy_run", 64'(busy), 64'd1);
        wr_base = n_writes;
        for (int i = 0; i < 16; i++) begin
            send(i % 4, 32'(i + 1), 1'b1);
            if (i == 0) begin
                check("first_req", 64'(mem_req), 64'd1);
                check("first_addr", 64'(mem_addr), 64'h1000);
            end
        end
        check("one_write_per_cycle", 64'(n_writes - wr_base), 64'd15);
        done_cnt = 0;
        done_cyc = -100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        check("done_once", 64'(done_cnt), 64'd1);
        check("done_latency", 64'(done_cyc - last_grant_cyc), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("sb_job_a", 64'(sb.size()), 64'd0);
        tick();

        // Overflow with grant held low: eight fit, the ninth is dropped.
        mem_gnt = 1'b0;
        start_job(32'h4000, 16'd8);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("err_before_ovf", 64'(err), 64'd0);
            send(i % 4, 32'(100 + i), i < 8);
        end
        check("err_ovf", 64'(err), 64'd1);
        repeat (4) tick();
`ifdef RESULT_WRITER_STALL_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'd12);
`endif
        mem_gnt = 1'b1;
        wait_drain(20);

        // Two strobes at once: only C11 is written.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        start_job(32'h2000, 16'd4);
        check("err_new_job", 64'(err), 64'd0);
        C11 = 32'h0000_0AAA;
        C12 = 32'h0000_0BBB;
        c11ready = 1'b1;
        c12ready = 1'b1;
        push_exp(0, 32'h0000_0AAA);
        tick();
        c11ready = 1'b0;
        c12ready = 1'b0;
        check("err_multi", 64'(err), 64'd1);
        wait_drain(10);
        repeat (3) tick();
        check("no_extra_req", 64'(mem_req), 64'd0);

        // Reset while a write is pending with three entries buffered.
        mem_gnt = 1'b0;
        send(1, 32'h21, 1'b1);
        send(2, 32'h22, 1'b1);
        send(3, 32'h23, 1'b1);
        check("req_before_rst", 64'(mem_req), 64'd1);
        #3 reset_n = 1'b0;
        #1;
        check("req_async_rst", 64'(mem_req), 64'd0);
        check("addr_async_rst", 64'(mem_addr), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mem_gnt = 1'b1;
        repeat (3) tick();
        check("req_after_rst", 64'(mem_req), 64'd0);
        check("err_after_rst", 64'(err), 64'd0);
        check("busy_after_rst", 64'(busy), 64'd0);

        // Degenerate size: done next cycle, no writes; idle strobe flags an error.
        start_job(32'h3000, 16'd1);
        check("done_small", 64'(done), 64'd1);
        check("req_small", 64'(mem_req), 64'd0);
        tick();
        check("done_small_end", 64'(done), 64'd0);
        check("busy_small", 64'(busy), 64'd0);
        send(2, 32'h55, 1'b0);
        check("err_idle_strobe", 64'(err), 64'd1);
        check("req_idle", 64'(mem_req), 64'd0);
        start_job(32'h3000, 16'd0);
        check("err_start_clear", 64'(err), 64'd0);
        repeat (3) tick();

        check("sb_final", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_writer.md
# result_writer

Write-back engine that sits downstream of the matrix multiplier core. It captures each 2x2 output tile element (C11, C12, C21, C22) on its one-cycle ready strobe and buffers it in a small FIFO. It then writes the element as a 32-bit word into a row-major NxN result matrix in memory, over an OBI-style request/grant write port. It counts tiles and pulses `done` after the last tile of a job has been granted.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: buffered elements; power of two, ≥4.
- `ADDR_W`, 32: memory address width.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job start; sampled only in IDLE.
- `base_addr`  in  ADDR_W  byte address of result element (0,0); latched on start.
- `size`  in  16  matrix dimension N (unsigned); latched on start.
- `c11ready`, `c12ready`, `c21ready`, `c22ready`  in  1 each  element-valid strobes.
- `C11`, `C12`, `C21`, `C22`  in  32 each  signed element data; valid in the cycle its strobe is high.
- `mem_req`  out  1  write request.
- `mem_we`  out  1  constant 1 while `mem_req` is high.
- `mem_addr`  out  ADDR_W  word-aligned byte address.
- `mem_wdata`  out  32  element data.
- `mem_gnt`  in  1  grant; the write completes in the cycle where `mem_req && mem_gnt`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  sticky error flag; cleared by an accepted start.

Reset values: `mem_req`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr`, `mem_wdata` = 0. The FIFO is empty, all counters are 0, and the state is IDLE.

## Operation
- Effective dimension: N_e = `size` & ~1. Tiles per row: T = N_e/2. Total tiles: T².
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start` when N_e ≥ 2. This latches `base_addr` and N_e, clears the tile counters (tr, tc), clears `row_base`, and clears `err`.
  - IDLE→DONE on `start` when N_e < 2. No writes are issued.
  - RUN→DONE when tiles_written == T² and the FIFO is empty.
  - DONE→IDLE unconditionally. `done` is high for exactly that one cycle.
- Capture: each strobe pushes {data, elem_idx[1:0]} into the FIFO (11=0, 12=1, 21=2, 22=3).
  - If several strobes are high in one cycle, only the highest-priority one is pushed (11>12>21>22). The others are dropped and `err` is set.
- Overflow: a strobe while the FIFO is full and not popping that cycle is dropped and sets `err`. A push is accepted when the FIFO is full but a pop happens in the same cycle.
- Strobes outside RUN are ignored and set `err`.
- Address generation uses no multiplier.
  - `row_base` holds 2·tr·N_e and advances by 2·N_e when tc wraps from T−1 to 0.
  - For r = elem_idx[1], c = elem_idx[0]: `mem_addr` = base + ((row_base + r·N_e + 2·tc + c) << 2), computed modulo 2^ADDR_W.
- Tile advance: when an element with elem_idx=3 is granted, tc increments. On wrap, tc returns to 0 and tr increments. tiles_written increments by 1.
- `start` during RUN or DONE is ignored.

## Timing
- A strobe in cycle t is written into the FIFO at the end of cycle t.
- If the FIFO was empty, `mem_req` rises in cycle t+1 with the address and data already valid.
- `mem_req`, `mem_addr` and `mem_wdata` are registered and stay stable until grant.
- After a grant, the next entry is presented in the following cycle. Sustained throughput is one write per cycle when `mem_gnt` is held at 1.
- `done` rises the cycle after the last element of the final tile is granted.
- Asserting `reset_n` low at any point aborts the job immediately and returns every output to its reset value; no partial write completes.

## Configuration
- `RESULT_WRITER_STALL_CNT_EN`:
  - Defined: adds output `stall_cycles` [31:0]. It counts cycles with `mem_req && !mem_gnt`, clears on an accepted start, and saturates at 0xFFFF_FFFF.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- `result_writer_pkg` holds:
  - the `wb_state_t` enum (IDLE/RUN/DONE);
  - the `elem_idx_t` typedef (2 bits) and the named constants for its four values;
  - the `wb_entry_t` struct {logic signed [31:0] data; elem_idx_t idx}.
- One sub-module, `wb_fifo`: a synchronous FIFO of `wb_entry_t` entries with full/empty flags, parameterised by `FIFO_DEPTH`.

## Test plan
- N=4, base=0x1000, `mem_gnt`=1, one tile with strobes on consecutive cycles, data 1,2,3,4 → writes 0x1000=1, 0x1004=2, 0x1010=3, 0x1014=4; one write per cycle, first `mem_req` one cycle after `c11ready`.
- N=4, four tiles with values 1–16 → tile (0,1) writes to 0x1008/0x100C/0x1018/0x101C, tile (1,0) writes to 0x1020/0x1024/0x1030/0x1034; `done` pulses once after the 16th grant, then `busy`=0.
- `mem_gnt`=0 for 12 cycles while 9 strobes arrive (`FIFO_DEPTH`=8) → the 9th element is dropped and `err`=1; with the macro defined, `stall_cycles`=12.
- `c11ready` and `c12ready` high in the same cycle → only C11 is written and `err`=1.
- `size`=1 with `start` → `done` pulses in the next cycle, no `mem_req` is raised; a strobe while IDLE sets `err`.
- `reset_n` dropped while `mem_req`=1 with 3 entries queued → `mem_req` goes to 0 immediately; after release the state is IDLE, the FIFO is empty and `err`=0.
